kpg_prefix_pipe: RTL and testbench

Pipelined recursive-doubling carry stage of the 16-bit recursive adder. It consumes the packed per-bit kill/propagate/generate code vector produced by the bit-level KPG encode stage. It resolves every bit's carry over log2(WIDTH) combine levels, one level per register stage, and emits the sum and carry-out under a valid/ready handshake. The ALU uses it as the adder back end, at full throughput: one add accepted per clock.

---
 rtl/kpg_prefix_pipe_pkg.sv | 14 +
 rtl/kpg_combine.sv | 12 +
 rtl/kpg_prefix_pipe.sv | 110 +++++++++++
 tb/tb_kpg_prefix_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/kpg_prefix_pipe_pkg.sv
// Shared kill/propagate/generate code definitions for the recursive adder carry stage.
package kpg_prefix_pipe_pkg;

  typedef logic [1:0] kpg_t;

  localparam kpg_t KPG_KILL = 2'b00;
  localparam kpg_t KPG_GEN  = 2'b11;

  // Both propagate codes (01, 10) have differing operand bits.
  function automatic logic kpg_is_prop(input kpg_t code);
    return code[1] ^ code[0];
  endfunction

endpackage

// File: rtl/kpg_combine.sv
// Two-code prefix operator: the upper code wins unless it propagates.
module kpg_combine
  import kpg_prefix_pipe_pkg::*;
(
  input  logic [1:0] hi,
  input  logic [1:0] lo,
  output logic [1:0] res
);

  assign res = kpg_is_prop(kpg_t'(hi)) ? lo : hi;

endmodule

// File: rtl/kpg_prefix_pipe.sv
// Pipelined recursive-doubling carry resolution, one combine level per stage.
// Optional signed-overflow output enabled by defining KPG_OVF_EN.
module kpg_prefix_pipe
  import kpg_prefix_pipe_pkg::*;
#(
  parameter  int unsigned WIDTH  = 16,
  localparam int unsigned LEVELS = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_kpg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_cout
`ifdef KPG_OVF_EN
  ,
  output logic               out_ovf
`endif
);

  localparam int unsigned CW = 2 * WIDTH;

  logic [LEVELS-1:0]            valid_q;
  logic [LEVELS-1:0]            adv;
  logic [LEVELS-1:0][CW-1:0]    code_d;
  logic [LEVELS-1:0][CW-1:0]    code_q;
  logic [LEVELS-1:0][WIDTH-1:0] prop_q;
  logic [WIDTH-1:0]             in_prop;
  logic [WIDTH-1:0]             gen;

  // Per-bit propagate, carried unmodified alongside the codes to form the sum.
  always_comb begin
    in_prop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_prop[i] = kpg_is_prop(kpg_t'(in_kpg[2*i +: 2]));
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int D = 2 ** k;
    logic [CW-1:0] src;

    if (k == 0) begin : g_first
      assign src = in_kpg;
    end else begin : g_next
      assign src = code_q[k-1];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [1:0] lo;
      // Bits below the doubling distance see the kill carry-in.
      if (i >= D) begin : g_far
        assign lo = src[2*(i-D) +: 2];
      end else begin : g_near
        assign lo = KPG_KILL;
      end
      kpg_combine u_comb (
        .hi  (src[2*i +: 2]),
        .lo  (lo),
        .res (code_d[k][2*i +: 2])
      );
    end

    // A stage moves unless it and every stage ahead of it are full and the sink stalls.
    assign adv[k] = out_ready || !(&valid_q[LEVELS-1:k]);
  end

  // Stage registers; a stage only loads when it advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      code_q  <= '0;
      prop_q  <= '0;
    end else begin
      if (adv[0]) begin
        valid_q[0] <= in_valid;
        code_q[0]  <= code_d[0];
        prop_q[0]  <= in_prop;
      end
      for (int k = 1; k < LEVELS; k++) begin
        if (adv[k]) begin
          valid_q[k] <= valid_q[k-1];
          code_q[k]  <= code_d[k];
          prop_q[k]  <= prop_q[k-1];
        end
      end
    end
  end

  // Fully resolved codes are kill or generate; generate means carry out of that bit.
  always_comb begin
    gen = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gen[i] = (kpg_t'(code_q[LEVELS-1][2*i +: 2]) == KPG_GEN);
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[LEVELS-1];
  assign out_sum   = prop_q[LEVELS-1] ^ {gen[WIDTH-2:0], 1'b0};
  assign out_cout  = gen[WIDTH-1];

`ifdef KPG_OVF_EN
  assign out_ovf = gen[WIDTH-1] ^ gen[WIDTH-2];
`endif

endmodule

// File: tb/tb_kpg_prefix_pipe.sv
// Self-checking bench for kpg_prefix_pipe: arithmetic scoreboard plus directed literal checks.
module tb_kpg_prefix_pipe;

  localparam int W = 16;
  localparam int L = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2*W-1:0] in_kpg;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
`ifdef KPG_OVF_EN
  logic          out_ovf;
`endif

  kpg_prefix_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kpg    (in_kpg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef KPG_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] res;
    logic        ovf;
    int          e_at;
  } exp_t;

  exp_t       q[$];
  logic [15:0] log_q[$];
  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  logic        hold_v = 1'b0;
  logic [16:0] hold_val;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] enc(input logic [15:0] a, input logic [15:0] b);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[2*i +: 2] = {a[i], b[i]};
    return r;
  endfunction

  always @(posedge clk) edge_cnt++;

  // Scoreboard: plain addition of the operands decoded from the codes.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_out_cout", 32'(out_cout), 32'd0);
      q.delete();
      hold_v = 1'b0;
    end else begin
      logic exp_ov;
      chk("in_ready", 32'(in_ready), 32'(!(q.size() == L && !out_ready)));
      exp_ov = (q.size() > 0) && (edge_cnt >= q[0].e_at + L - 1);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (out_valid && q.size() > 0) begin
        chk("sum_cout", 32'({out_cout, out_sum}), 32'(q[0].res));
`ifdef KPG_OVF_EN
        chk("ovf", 32'(out_ovf), 32'(q[0].ovf));
`endif
      end
      if (hold_v) chk("stall_stable", 32'({out_valid, out_cout, out_sum}), 32'({1'b1, hold_val}));
      hold_v   = out_valid && !out_ready;
      hold_val = {out_cout, out_sum};
      if (out_valid && out_ready && q.size() > 0) begin
        log_q.push_back(out_sum);
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        logic [15:0] a, b;
        exp_t e;
        for (int i = 0; i < W; i++) begin
          a[i] = in_kpg[2*i+1];
          b[i] = in_kpg[2*i];
        end
        e.res  = {1'b0, a} + {1'b0, b};
        e.ovf  = (a[15] == b[15]) && (e.res[15] != a[15]);
        e.e_at = edge_cnt + 1;
        q.push_back(e);
      end
    end
  end

  task automatic single(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] es, input logic ec, input logic eo, input string nm);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_kpg    = enc(a, b);
    #1 chk({nm, "_acc"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(L - 1));
    chk({nm, "_sum"}, 32'(out_sum), 32'(es));
    chk({nm, "_cout"}, 32'(out_cout), 32'(ec));
`ifdef KPG_OVF_EN
    chk({nm, "_ovf"}, 32'(out_ovf), 32'(eo));
`else
    if (eo) n = n;
`endif
    @(posedge clk); #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
    #1 chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int idx, c, drops, first_drop, sent, cyc;
    rst = 1'b1; in_valid = 1'b0; in_kpg = '0; out_ready = 1'b1;
    #1;
    chk("init_valid", 32'(out_valid), 32'd0);
    chk("init_ready", 32'(in_ready), 32'd1);
    chk("init_sum", 32'({out_cout, out_sum}), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    single(16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, "add_5555");
    single(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, "ripple");
    single(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, "ovf");

    // Back-to-back 1+1 .. 8+8 with the sink stalled in cycles 3..5.
    log_q.delete();
    idx = 0; c = 0; drops = 0; first_drop = -1;
    while (idx < 8 && c < 50) begin
      logic acc;
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = 1'b1;
      in_kpg    = enc(16'(idx + 1), 16'(idx + 1));
      @(negedge clk);
      acc = in_ready;
      if (!in_ready) begin
        drops++;
        if (first_drop < 0) first_drop = c;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      c++;
    end
    drain();
    chk("b2b_count", 32'(log_q.size()), 32'd8);
    for (int j = 0; j < 8 && j < log_q.size(); j++) chk("b2b_val", 32'(log_q[j]), 32'(2 * (j + 1)));
    chk("b2b_drops", 32'(drops), 32'd2);
    chk("b2b_first_drop", 32'(first_drop), 32'd4);

    // Three adds in flight, the oldest waiting at the output, then async reset mid-cycle.
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_kpg   = enc(16'(100 + j), 16'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_ready", 32'(in_ready), 32'd1);
    chk("async_sum", 32'(out_sum), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    single(16'd5, 16'd3, 16'd8, 1'b0, 1'b0, "post_rst");
    chk("post_rst_idle", 32'(out_valid), 32'd0);

    // Random operands with random valid/ready.
    sent = 0; cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      in_kpg    = enc(16'($urandom), 16'($urandom));
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_sent", 32'(sent), 32'd1000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
